// File: rtl/tbus_sram_responder.sv
// tbus responder backed by a doubleword SRAM array.
// Accepts one request at a time, completes it a fixed LATENCY cycles later with
// a one-cycle done pulse, and lets the LSU flush line cancel in-flight work.

package tbus_pkg;
    typedef logic [1:0] tbus_optype_t;
    localparam tbus_optype_t TBUS_READ  = 2'd0;
    localparam tbus_optype_t TBUS_WRITE = 2'd1;
endpackage

module tbus_sram_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2    // legal range 1..15 (fits the 4-bit counter)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       tbus_index_valid,
    output logic                       tbus_index_ready,
    input  logic [63:0]                tbus_index,
    input  logic [63:0]                tbus_write_data,
    input  logic [63:0]                tbus_write_mask,
    input  tbus_pkg::tbus_optype_t     tbus_operation_type,
    output logic [63:0]                tbus_read_data,
    output logic                       tbus_operation_done,
    input  logic                       flush,
    output logic                       busy
);
    import tbus_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [63:0]             wdata_q;
    logic [63:0]             mask_q;
    tbus_optype_t            op_q;
    logic [63:0]             rdata_q;
    logic                    busy_q;

    logic [63:0]             mem [0:(2**DEPTH_LOG2)-1];

    logic                    fire;
    logic                    done_cycle;
    logic                    commit_write;
    logic                    commit_read;
    logic                    clear_rdata;

    // Address bits outside the doubleword index never affect the access.
    logic                    unused_index_bits;
    assign unused_index_bits = ^{tbus_index[63:DEPTH_LOG2+3], tbus_index[2:0]};

    assign tbus_index_ready    = (state_q == S_IDLE) & ~flush;
    assign fire                = tbus_index_valid & tbus_index_ready;
    assign done_cycle          = (state_q == S_BUSY) && (cnt_q == 4'd0);
    assign tbus_operation_done = done_cycle | (state_q == S_ABORT);
    assign tbus_read_data      = rdata_q;
    assign busy                = busy_q;

    // A flush in the done cycle still completes the handshake but commits nothing.
    // Reset gates the array write so a reset in the done cycle drops the store.
    assign commit_write = done_cycle & ~flush & reset_n & (op_q == TBUS_WRITE);
    assign commit_read  = done_cycle & ~flush & (op_q == TBUS_READ);
    assign clear_rdata  = (done_cycle & flush) | (state_q == S_ABORT);

    // Next-state logic: accept in IDLE, count down in BUSY, one-cycle ABORT.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (fire) begin
                    state_d = S_BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else if (flush) begin
                    state_d = S_ABORT;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Control state, busy flag and read-data register with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != S_IDLE);
            if (commit_read) begin
                rdata_q <= mem[idx_q];
            end else if (clear_rdata) begin
                rdata_q <= '0;
            end
        end
    end

    // Request capture: inputs are sampled only at fire and ignored afterwards.
    always_ff @(posedge clock) begin
        if (fire) begin
            idx_q   <= tbus_index[DEPTH_LOG2+2:3];
            wdata_q <= tbus_write_data;
            mask_q  <= tbus_write_mask;
            op_q    <= tbus_operation_type;
        end
    end

    // Bit-masked read-modify-write of the addressed doubleword.
    always_ff @(posedge clock) begin
        // NOTE: the array carries no reset; it maps onto block RAM and its contents survive reset by design.
        if (commit_write) begin
            mem[idx_q] <= (mem[idx_q] & ~mask_q) | (wdata_q & mask_q);
        end
    end

endmodule
